// File: rtl/apb_pkg.sv
// Shared encodings and arbiter state type for the APB transfer arbiter.
package apb_pkg;

    localparam logic [1:0] ENC_WR = 2'b01;
    localparam logic [1:0] ENC_RD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_t;

    function automatic logic enc_legal(input logic [1:0] enc);
        return (enc == ENC_WR) || (enc == ENC_RD);
    endfunction

endpackage

// File: rtl/apb_trf_arbiter_rr.sv
// Combinational round-robin pick: first active request after last_gnt, wrapping.
module rr_arbiter
    import apb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GNT_W-1:0]   idx,
    output logic               valid
);

    int dist_s;
    int best_s;
    int best_idx_s;

    // Smallest circular distance from last_gnt+1 wins
    always_comb begin
        dist_s     = 0;
        best_s     = NUM_REQ;
        best_idx_s = 0;
        gnt        = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j > int'(last_gnt)) begin
                dist_s = j - int'(last_gnt) - 1;
            end else begin
                dist_s = j + NUM_REQ - int'(last_gnt) - 1;
            end
            if (req[j] && (dist_s < best_s)) begin
                best_s     = dist_s;
                best_idx_s = j;
            end else begin
                best_s     = best_s;
            end
        end
        valid = (best_s < NUM_REQ);
        idx   = GNT_W'(best_idx_s);
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j] = valid && (best_idx_s == j);
        end
    end

endmodule

// File: rtl/apb_trf_arbiter.sv
// Shares one apb_master transfer port among NUM_REQ requesters, round-robin,
// with per-transfer timeout and rejection of illegal encodings.
module apb_trf_arbiter
    import apb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ADDR_W      = 8,
    parameter  int DATA_W      = 8,
    parameter  int TIMEOUT_CYC = 16,
    localparam int GNT_W       = $clog2(NUM_REQ)
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_enc,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      trf_valid,
    output logic [1:0]                trf_enc,
    output logic [ADDR_W-1:0]         trf_addr,
    output logic [DATA_W-1:0]         trf_wdata,
    input  logic [DATA_W-1:0]         trf_rdata,
    input  logic                      trf_rdata_valid,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pready,
    output logic                      busy,
    output logic [GNT_W-1:0]          gnt_idx
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t          state_r;
    logic [GNT_W-1:0]    last_gnt_r;
    logic [NUM_REQ-1:0]  gnt_oh_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [NUM_REQ-1:0]  arb_gnt_s;
    logic [GNT_W-1:0]    arb_idx_s;
    logic                arb_valid_s;
    logic [1:0]          sel_enc_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                apb_done_s;
    logic                timeout_hit_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (req_valid),
        .last_gnt (last_gnt_r),
        .gnt      (arb_gnt_s),
        .idx      (arb_idx_s),
        .valid    (arb_valid_s)
    );

    // Select the winning requester's fields
    always_comb begin
        sel_enc_s   = 2'b00;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_gnt_s[j]) begin
                sel_enc_s   = req_enc[2*j +: 2];
                sel_addr_s  = req_addr[ADDR_W*j +: ADDR_W];
                sel_wdata_s = req_wdata[DATA_W*j +: DATA_W];
            end else begin
                sel_enc_s   = sel_enc_s;
            end
        end
    end

    assign apb_done_s    = psel & penable & pready;
    assign timeout_hit_s = (TIMEOUT_CYC > 0) && (int'(cnt_r) == TIMEOUT_CYC - 1);

    // Arbiter FSM; all outputs registered, done beats timeout in the same cycle
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= GNT_W'(NUM_REQ - 1);
            gnt_oh_r   <= '0;
            cnt_r      <= '0;
            req_ack    <= '0;
            req_done   <= '0;
            req_err    <= 1'b0;
            req_rdata  <= '0;
            trf_valid  <= 1'b0;
            trf_enc    <= 2'b00;
            trf_addr   <= '0;
            trf_wdata  <= '0;
            busy       <= 1'b0;
            gnt_idx    <= '0;
        end else begin
            req_ack   <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
            case (state_r)
                ST_IDLE: begin
                    trf_valid <= 1'b0;
                    cnt_r     <= '0;
                    if (arb_valid_s) begin
                        last_gnt_r <= arb_idx_s;
                        gnt_idx    <= arb_idx_s;
                        gnt_oh_r   <= arb_gnt_s;
                        trf_enc    <= sel_enc_s;
                        trf_addr   <= sel_addr_s;
                        trf_wdata  <= sel_wdata_s;
                        req_ack    <= arb_gnt_s;
                        busy       <= 1'b1;
                        if (enc_legal(sel_enc_s)) begin
                            state_r   <= ST_BUSY;
                            trf_valid <= 1'b1;
                        end else begin
                            state_r   <= ST_RESP;
                            req_done  <= arb_gnt_s;
                            req_err   <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (apb_done_s) begin
                        state_r   <= ST_RESP;
                        trf_valid <= 1'b0;
                        req_done  <= gnt_oh_r;
                        req_rdata <= ((trf_enc == ENC_RD) && trf_rdata_valid) ? trf_rdata : '0;
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_DRAIN;
                        trf_valid <= 1'b0;
                        req_done  <= gnt_oh_r;
                        req_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    trf_valid <= 1'b0;
                    if (!psel) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        busy    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    trf_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    trf_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_trf_arbiter.sv
// Scoreboard bench: a round-robin reference model predicts grants and responses,
// a monitor compares them as the arbiter presents acks and dones.
module tb_apb_trf_arbiter;
    import apb_pkg::*;

    localparam int NR  = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic            pclk = 1'b0;
    logic            prst;
    logic [NR-1:0]   req_valid;
    logic [2*NR-1:0] req_enc;
    logic [AW*NR-1:0] req_addr;
    logic [DW*NR-1:0] req_wdata;
    logic [NR-1:0]   req_ack, req_done;
    logic            req_err;
    logic [DW-1:0]   req_rdata;
    logic            trf_valid;
    logic [1:0]      trf_enc;
    logic [AW-1:0]   trf_addr;
    logic [DW-1:0]   trf_wdata;
    logic [DW-1:0]   trf_rdata;
    logic            trf_rdata_valid, psel, penable, pready, busy;
    logic [1:0]      gnt_idx;

    apb_trf_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .pclk(pclk), .prst(prst), .req_valid(req_valid), .req_enc(req_enc),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_done(req_done),
        .req_err(req_err), .req_rdata(req_rdata), .trf_valid(trf_valid), .trf_enc(trf_enc),
        .trf_addr(trf_addr), .trf_wdata(trf_wdata), .trf_rdata(trf_rdata),
        .trf_rdata_valid(trf_rdata_valid), .psel(psel), .penable(penable), .pready(pready),
        .busy(busy), .gnt_idx(gnt_idx)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int         idx;
        logic       legal;
        logic [1:0] enc;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       err;
        logic [7:0] rdata;
        logic       tmo;
    } exp_t;

    exp_t  ack_q[$];
    exp_t  done_q[$];
    string snap_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    deadline = 1000000;
    logic  stall    = 1'b0;
    int    model_last = NR - 1;

    logic [1:0] t_enc[NR][8];
    logic [7:0] t_addr[NR][8];
    logic [7:0] t_wdata[NR][8];
    int         t_cnt[NR];
    int         t_ptr[NR];

    function automatic logic [7:0] slave_data(input logic [7:0] a);
        return a ^ 8'h7C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT acks or completes
    initial begin : monitor
        int    run_len;
        int    last_done;
        logic  dw, dw_prev;
        exp_t  e;
        string s;
        run_len = 0; last_done = -100; dw = 1'b0; dw_prev = 1'b0;
        forever begin
            @(negedge pclk);
            cyc++;
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk(s, 64'({req_ack, req_done, req_err, req_rdata, trf_valid, trf_enc,
                            trf_addr, trf_wdata, busy, gnt_idx}), 64'd0);
            end
            if (prst) begin
                run_len = 0; last_done = -100; dw = 1'b0;
            end else begin
                if (dw) begin
                    if (!dw_prev) begin
                        chk("drain_exit_busy", 64'(busy), 64'd0);
                        dw = 1'b0;
                    end else begin
                        chk("drain_hold_busy", 64'(busy), 64'd1);
                        dw_prev = psel;
                    end
                end
                if (req_ack != '0) begin
                    run_len = 0;
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", 64'(req_ack), 64'd0);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_onehot", 64'(req_ack), 64'd1 << e.idx);
                        chk("ack_gnt_idx", 64'(gnt_idx), 64'(e.idx));
                        chk("ack_trf_valid", 64'(trf_valid), 64'(e.legal));
                        chk("ack_gap", 64'(cyc - last_done >= 2), 64'd1);
                        if (e.legal)
                            chk("trf_fields", 64'({trf_enc, trf_addr, trf_wdata}),
                                64'({e.enc, e.addr, e.wdata}));
                    end
                end
                if (trf_valid) run_len++;
                if (req_done != '0) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 64'(req_done), 64'd0);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_onehot", 64'(req_done), 64'd1 << e.idx);
                        chk("done_err", 64'(req_err), 64'(e.err));
                        chk("done_rdata", 64'(req_rdata), 64'(e.rdata));
                        chk("done_trf_valid_low", 64'(trf_valid), 64'd0);
                        chk("done_busy", 64'(busy), 64'd1);
                        if (e.tmo) begin
                            chk("timeout_busy_cycles", 64'(run_len), 64'(TMO));
                            dw = 1'b1;
                            dw_prev = psel;
                        end
                    end
                    last_done = cyc;
                end
                if (cyc > deadline && (ack_q.size() + done_q.size()) > 0) begin
                    chk("watchdog_pending", 64'(ack_q.size() + done_q.size()), 64'd0);
                    ack_q.delete();
                    done_q.delete();
                end
            end
        end
    end

    // APB side: setup, access with random wait states, optional stall until drained
    initial begin : apb_slave
        int phase, wait_left, drain_cnt;
        phase = 0; wait_left = 0; drain_cnt = 0;
        psel = 1'b0; penable = 1'b0; pready = 1'b0; trf_rdata = 8'h00; trf_rdata_valid = 1'b0;
        forever begin
            @(posedge pclk); #2;
            if (prst) begin
                psel = 1'b0; penable = 1'b0; pready = 1'b0; trf_rdata_valid = 1'b0; phase = 0;
            end else if (phase == 0) begin
                if (trf_valid) begin psel = 1'b1; phase = 1; drain_cnt = 0; end
            end else if (phase == 1) begin
                penable = 1'b1; wait_left = $urandom_range(0, 2); phase = 2;
            end else if (pready) begin
                psel = 1'b0; penable = 1'b0; pready = 1'b0; trf_rdata_valid = 1'b0; phase = 0;
            end else if (stall) begin
                if (!trf_valid) drain_cnt++;
                if (drain_cnt >= 3) begin psel = 1'b0; penable = 1'b0; phase = 0; end
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                pready = 1'b1;
                trf_rdata_valid = (trf_enc == ENC_RD);
                trf_rdata = (trf_enc == ENC_RD) ? slave_data(trf_addr) : 8'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge pclk); #1;
    endtask

    task automatic do_reset();
        prst = 1'b1; req_valid = '0;
        tick();
        snap_q.push_back("reset_outputs_zero");
        tick();
        prst = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < NR; i++) t_cnt[i] = 0;
    endtask

    task automatic set_req(input int i, input int k, input logic [1:0] enc,
                           input logic [7:0] addr, input logic [7:0] wdata);
        t_enc[i][k] = enc; t_addr[i][k] = addr; t_wdata[i][k] = wdata;
        if (t_cnt[i] < k + 1) t_cnt[i] = k + 1;
    endtask

    task automatic load(input int i, input int k);
        req_enc[2*i +: 2]     = t_enc[i][k];
        req_addr[AW*i +: AW]  = t_addr[i][k];
        req_wdata[DW*i +: DW] = t_wdata[i][k];
    endtask

    function automatic exp_t make_exp(input int i, input int k, input logic stall_mode);
        exp_t e;
        e.idx   = i;
        e.enc   = t_enc[i][k];
        e.addr  = t_addr[i][k];
        e.wdata = t_wdata[i][k];
        e.legal = (e.enc == 2'b01) || (e.enc == 2'b10);
        e.err   = !e.legal || stall_mode;
        e.rdata = (!e.err && e.enc == 2'b10) ? slave_data(e.addr) : 8'h00;
        e.tmo   = e.legal && stall_mode;
        return e;
    endfunction

    // Raise all requests of the table at once; requesters hold until their count is served
    task automatic run_batch(input logic stall_mode);
        int   rem[NR];
        int   lg, total, cand;
        logic picked;
        exp_t e;
        total = 0;
        for (int i = 0; i < NR; i++) begin rem[i] = t_cnt[i]; total += t_cnt[i]; t_ptr[i] = 0; end
        lg = model_last;
        for (int n = 0; n < total; n++) begin
            picked = 1'b0;
            for (int d = 1; d <= NR; d++) begin
                cand = (lg + d) % NR;
                if (!picked && rem[cand] > 0) begin
                    e = make_exp(cand, t_cnt[cand] - rem[cand], stall_mode);
                    ack_q.push_back(e);
                    done_q.push_back(e);
                    rem[cand]--;
                    lg = cand;
                    picked = 1'b1;
                end
            end
        end
        model_last = lg;
        stall = stall_mode;
        for (int i = 0; i < NR; i++) begin
            if (t_cnt[i] > 0) load(i, 0);
            req_valid[i] = (t_cnt[i] > 0);
        end
        deadline = cyc + 60 * total + 20;
        for (int c = 0; c < 60 * total + 40 && (ack_q.size() + done_q.size()) > 0; c++) begin
            @(negedge pclk);
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i] && req_valid[i]) begin
                    t_ptr[i]++;
                    if (t_ptr[i] < t_cnt[i]) load(i, t_ptr[i]);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        repeat (6) tick();
        stall = 1'b0;
    endtask

    initial begin : guard
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int r;
        exp_t e;
        prst = 1'b1; req_valid = '0; req_enc = '0; req_addr = '0; req_wdata = '0;
        tick();
        do_reset();

        clear_tbl();
        set_req(0, 0, ENC_WR, 8'h10, 8'hA5);
        run_batch(1'b0);

        do_reset();
        clear_tbl();
        for (int i = 0; i < NR; i++) set_req(i, 0, ENC_WR, 8'(8'h40 + i), 8'($urandom));
        set_req(0, 1, ENC_RD, 8'h55, 8'h00);
        run_batch(1'b0);

        clear_tbl();
        set_req(2, 0, ENC_RD, 8'h20, 8'h00);
        run_batch(1'b0);

        clear_tbl();
        set_req(1, 0, 2'b11, 8'h33, 8'h44);
        run_batch(1'b0);

        clear_tbl();
        set_req(3, 0, ENC_WR, 8'h77, 8'h88);
        run_batch(1'b1);

        // Reset in the middle of a stalled transfer
        clear_tbl();
        set_req(2, 0, ENC_RD, 8'h66, 8'h00);
        e = make_exp(2, 0, 1'b1);
        ack_q.push_back(e);
        stall = 1'b1;
        load(2, 0);
        req_valid[2] = 1'b1;
        deadline = cyc + 20;
        for (int c = 0; c < 30 && ack_q.size() > 0; c++) @(negedge pclk);
        req_valid[2] = 1'b0;
        repeat (4) tick();
        prst = 1'b1;
        tick();
        snap_q.push_back("midbusy_reset_zero");
        prst = 1'b0;
        model_last = NR - 1;
        stall = 1'b0;
        repeat (3) tick();
        clear_tbl();
        for (int i = 0; i < NR; i++) set_req(i, 0, ENC_RD, 8'($urandom), 8'h00);
        run_batch(1'b0);

        for (int b = 0; b < 12; b++) begin
            clear_tbl();
            for (int i = 0; i < NR; i++) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    r = $urandom_range(0, 7);
                    set_req(i, k, (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? ENC_WR : ENC_RD,
                            8'($urandom), 8'($urandom));
                end
            end
            run_batch(1'b0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
